// File: rtl/pio_fir_engine.sv
// Sequential-MAC FIR engine behind a toggle-handshake PIO command word.
// Commands push samples, load coefficients or clear history; results come back with an ack toggle.
module pio_fir_engine #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 8,
    parameter int TAPS   = 8,
    parameter int SHIFT  = 7,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       inp,
    output logic [OUT_W-1:0]  outp
);

    localparam int IW     = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
    localparam int RES_W  = OUT_W - 2;

    localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'((1 << SHIFT) >> 1);
    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((1 << (RES_W-1)) - 1);
    localparam logic signed [ACC_W:0] MINV = (ACC_W+1)'(-(1 << (RES_W-1)));

    localparam logic [1:0] CMD_PUSH  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_CLEAR = 2'd2;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_SHIFT, S_MAC, S_OUT, S_ACK
    } state_t;

    state_t state_q, state_d;

    logic [31:0]               sync1, sync2;
    logic                      last_req;
    logic [1:0]                init_cnt;
    logic [IW-1:0]             mac_i;
    logic signed [DATA_W-1:0]  sample_q;
    logic signed [DATA_W-1:0]  hist [TAPS];
    logic signed [COEF_W-1:0]  coef [TAPS];
    logic signed [ACC_W-1:0]   acc;

    logic                      pending;
    logic [1:0]                cmd;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W:0]     rsum, rsh;
    logic [RES_W-1:0]          res;
    logic                      sat;
    logic                      unused_sync;

    assign unused_sync = ^sync2;
    assign pending     = sync2[31] != last_req;
    assign cmd         = sync2[30:29];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (init_cnt == 2'd2) state_d = S_IDLE;
            S_IDLE:  if (pending) state_d = (cmd == CMD_PUSH) ? S_SHIFT : S_ACK;
            S_SHIFT: state_d = S_MAC;
            S_MAC:   if (mac_i == IW'(TAPS-1)) state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    // Round-half-up, arithmetic shift, then clamp into the signed result field.
    always_comb begin
        prod = coef[mac_i] * hist[mac_i];
        rsum = $signed({acc[ACC_W-1], acc}) + RND;
        rsh  = rsum >>> SHIFT;
        sat  = 1'b0;
        res  = rsh[RES_W-1:0];
        if (rsh > MAXV) begin
            res = MAXV[RES_W-1:0];
            sat = 1'b1;
        end else if (rsh < MINV) begin
            res = MINV[RES_W-1:0];
            sat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_INIT;
            sync1    <= '0;
            sync2    <= '0;
            last_req <= 1'b0;
            init_cnt <= '0;
            mac_i    <= '0;
            sample_q <= '0;
            acc      <= '0;
            outp     <= '0;
            for (int k = 0; k < TAPS; k++) begin
                hist[k] <= '0;
                coef[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            sync1   <= inp;
            sync2   <= sync1;
            case (state_q)
                // Prime last_req once the synchronizer has settled so a req level held
                // across reset release is not taken as a request.
                S_INIT: begin
                    init_cnt <= init_cnt + 2'd1;
                    if (init_cnt == 2'd2) last_req <= sync2[31];
                end
                S_IDLE: begin
                    if (pending) begin
                        last_req <= sync2[31];
                        sample_q <= sync2[DATA_W-1:0];
                        if (cmd == CMD_LOAD && int'(sync2[28:24]) < TAPS)
                            coef[sync2[24 +: IW]] <= sync2[COEF_W-1:0];
                        if (cmd == CMD_CLEAR)
                            for (int k = 0; k < TAPS; k++) hist[k] <= '0;
                    end
                end
                S_SHIFT: begin
                    for (int k = TAPS-1; k > 0; k--) hist[k] <= hist[k-1];
                    hist[0] <= sample_q;
                    acc     <= '0;
                    mac_i   <= '0;
                end
                S_MAC: begin
                    acc   <= acc + ACC_W'(prod);
                    mac_i <= mac_i + IW'(1);
                end
                S_OUT: outp <= {~outp[OUT_W-1], sat, res};
                S_ACK: outp[OUT_W-1] <= ~outp[OUT_W-1];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pio_fir_engine.sv
// Directed bench for pio_fir_engine: a reference model pushes expected outp words to a queue
// as commands are issued, and each ack pops and compares one.
module tb_pio_fir_engine;

    localparam int DATA_W = 16;
    localparam int COEF_W = 8;
    localparam int TAPS   = 8;
    localparam int SHIFT  = 7;
    localparam int OUT_W  = 16;
    localparam int RES_W  = OUT_W - 2;
    localparam longint MAXR = (longint'(1) << (RES_W-1)) - 1;
    localparam longint MINR = -(longint'(1) << (RES_W-1));

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       inp;
    logic [OUT_W-1:0]  outp;

    always #5 clk = ~clk;

    pio_fir_engine #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .SHIFT(SHIFT), .OUT_W(OUT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .inp   (inp),
        .outp  (outp)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [OUT_W-1:0] exp_q[$];

    int               coef_m [TAPS];
    int               hist_m [TAPS];
    logic             m_ack, m_sat;
    logic [RES_W-1:0] m_res;
    logic             req;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < TAPS; k++) begin
            coef_m[k] = 0;
            hist_m[k] = 0;
        end
        m_ack = 1'b0;
        m_sat = 1'b0;
        m_res = '0;
    endfunction

    // Update the model, queue the expected outp, then drive the command with a fresh toggle.
    task automatic fire(input logic [1:0] cmd, input logic [4:0] idx, input logic [15:0] data);
        longint acc, r, rnd;
        case (cmd)
            2'd0: begin
                for (int k = TAPS-1; k > 0; k--) hist_m[k] = hist_m[k-1];
                hist_m[0] = int'($signed(data));
                acc = 0;
                for (int k = 0; k < TAPS; k++) acc += longint'(coef_m[k]) * longint'(hist_m[k]);
                rnd = (SHIFT > 0) ? (longint'(1) << (SHIFT-1)) : 0;
                r = (acc + rnd) >>> SHIFT;
                m_sat = 1'b0;
                if (r > MAXR) begin
                    r = MAXR;
                    m_sat = 1'b1;
                end else if (r < MINR) begin
                    r = MINR;
                    m_sat = 1'b1;
                end
                m_res = r[RES_W-1:0];
            end
            2'd1: if (idx < TAPS) coef_m[idx] = int'($signed(data[COEF_W-1:0]));
            2'd2: for (int k = 0; k < TAPS; k++) hist_m[k] = 0;
            default: ;
        endcase
        m_ack = ~m_ack;
        exp_q.push_back({m_ack, m_sat, m_res});
        @(negedge clk);
        req = ~req;
        inp = {req, cmd, idx, 8'h00, data};
    endtask

    // lat counts edges from edge 0 (first posedge after the command was driven).
    task automatic wait_ack(input string tag, output int lat);
        logic [OUT_W-1:0] prev, e;
        prev = outp;
        lat  = -1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            lat++;
            #1;
            if (outp !== prev) break;
        end
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'(exp_q.size()), 1);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'(outp), 32'(e));
        end
    endtask

    task automatic toggle_only();
        @(negedge clk);
        req = ~req;
        inp[31] = req;
    endtask

    task automatic quiet(input string tag, input int cycles);
        logic [OUT_W-1:0] prev;
        logic changed;
        prev = outp;
        changed = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (outp !== prev) changed = 1'b1;
        end
        check(tag, 32'(changed), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        // Reset with req held high: release must not look like a request.
        reset = 1'b1;
        inp   = 32'h8000_0000;
        req   = 1'b1;
        model_reset();
        repeat (5) @(posedge clk);
        #1;
        check("reset_outp", 32'(outp), 0);
        @(negedge clk);
        reset = 1'b0;
        quiet("no_ack_after_reset", 20);

        fire(2'd1, 5'd0, 16'd127);
        wait_ack("load_c0", lat);
        check("load_ack_edge", lat, 3);
        fire(2'd0, 5'd0, 16'd100);
        wait_ack("push100", lat);
        check("push_ack_edge", lat, 12);
        check("push100_res", 32'(outp[RES_W-1:0]), 99);

        // Out-of-range index must not alias onto a real tap.
        fire(2'd1, 5'd9, 16'd5);
        wait_ack("load_idx9", lat);
        fire(2'd0, 5'd0, 16'd0);
        wait_ack("push0_after_idx9", lat);

        fire(2'd2, 5'd0, 16'd0);
        wait_ack("clear1", lat);
        check("clear_ack_edge", lat, 3);
        for (int k = 0; k < TAPS; k++) begin
            fire(2'd1, 5'(k), 16'd16);
            wait_ack("load16", lat);
        end
        fire(2'd0, 5'd0, 16'd1000);
        wait_ack("push1000_first", lat);
        check("push1000_first_res", 32'(outp[RES_W-1:0]), 125);
        for (int k = 1; k < TAPS; k++) begin
            fire(2'd0, 5'd0, 16'd1000);
            wait_ack("push1000", lat);
        end
        check("push1000_full_res", 32'(outp[RES_W-1:0]), 1000);
        check("push1000_full_sat", 32'(outp[OUT_W-2]), 0);

        for (int k = 0; k < TAPS; k++) begin
            fire(2'd1, 5'(k), 16'd127);
            wait_ack("load127", lat);
        end
        for (int k = 0; k < TAPS; k++) begin
            fire(2'd0, 5'd0, 16'd32767);
            wait_ack("push_max", lat);
        end
        check("pos_sat_res", 32'(outp[RES_W-1:0]), 32'h1FFF);
        check("pos_sat_flag", 32'(outp[OUT_W-2]), 1);

        fire(2'd2, 5'd0, 16'd0);
        wait_ack("clear2", lat);
        for (int k = 1; k < TAPS; k++) begin
            fire(2'd1, 5'(k), 16'd0);
            wait_ack("load0", lat);
        end
        fire(2'd0, 5'd0, 16'h8000);
        wait_ack("push_min", lat);
        check("neg_sat_res", 32'(outp[RES_W-1:0]), 32'h2000);
        check("neg_sat_flag", 32'(outp[OUT_W-2]), 1);

        fire(2'd3, 5'd0, 16'd0);
        wait_ack("nop", lat);
        check("nop_ack_edge", lat, 3);

        // Second request raised while the first is in MAC is served once afterwards.
        fire(2'd0, 5'd0, 16'd200);
        repeat (6) @(posedge clk);
        fire(2'd0, 5'd0, 16'd300);
        wait_ack("push200_busy", lat);
        wait_ack("push300_deferred", lat);
        quiet("deferred_once", 30);

        // Two toggles inside one busy window cancel out.
        fire(2'd0, 5'd0, 16'd400);
        repeat (4) @(posedge clk);
        toggle_only();
        repeat (2) @(posedge clk);
        toggle_only();
        wait_ack("push400", lat);
        quiet("double_toggle_no_ack", 30);

        // Reset mid-MAC abandons the push and clears everything.
        @(negedge clk);
        req = ~req;
        inp = {req, 2'd0, 5'd0, 8'h00, 16'd500};
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_mid_mac", 32'(outp), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (6) @(posedge clk);
        check("reset_no_spurious_ack", 32'(outp), 0);
        fire(2'd0, 5'd0, 16'd100);
        wait_ack("push_after_reset", lat);
        check("push_after_reset_outp", 32'(outp), 32'h8000);

        check("queue_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pio_fir_engine.md
# pio_fir_engine

Parametrised FIR engine that replaces the fixed filter interface between HPS PIO 0 (command word in) and PIO 1 (result word out) on the DE1-SoC top level. The HPS pushes samples, loads coefficients, or clears history through a toggle handshake carried in the PIO word. The block runs a sequential multiply-accumulate over TAPS history entries, then rounds, shifts and saturates the sum. It returns the result with an ack toggle and a saturation flag.

## Interface
- DATA_W, 16, signed sample width (≤16)
- COEF_W, 8, signed coefficient width (≤16)
- TAPS, 8, filter length (2..32)
- SHIFT, 7, arithmetic right shift applied to accumulator (0..COEF_W+4)
- OUT_W, 16, output PIO width (≥4)

- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- inp  in  32  command word: [31] req toggle, [30:29] cmd, [28:24] coef index, [DATA_W-1:0] sample / [COEF_W-1:0] coefficient
- outp  out  OUT_W  [OUT_W-1] ack toggle, [OUT_W-2] sat flag, [OUT_W-3:0] signed result

## Operation
- Input path:
  - inp passes through 2-flop register stages sync1 and sync2.
  - A request is pending when sync2[31] != last_req.
- Commands:
  - 00 PUSH: shift history (h[0] newest, h[TAPS-1] dropped), load h[0]=sample, compute, publish.
  - 01 LOAD: coef[index]=low COEF_W bits. An index ≥ TAPS is ignored. Ack only.
  - 10 CLEAR: all history entries = 0. Ack only.
  - 11 NOP: ack only.
- FSM states: INIT, IDLE, SHIFT, MAC, OUT, ACK.
  - INIT: entered on reset. Holds 2 cycles, then last_req <= sync2[31]. Go to IDLE.
  - IDLE: on a pending request, latch cmd/index/data and set last_req <= sync2[31]. PUSH → SHIFT. Other commands perform their action → ACK.
  - SHIFT: 1 cycle. Shift history, clear acc.
  - MAC: TAPS cycles. Index i counts 0..TAPS-1; acc += coef[i]*h[i]. At i = TAPS-1 → OUT.
  - OUT: form result, update outp (result, sat flag, ack inverted) → IDLE.
  - ACK: invert outp ack bit only. Result and sat flag are held → IDLE.
- Arithmetic:
  - Product width is DATA_W+COEF_W. Accumulator width is DATA_W+COEF_W+clog2(TAPS), signed.
  - r = (acc + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT.
  - Clamp r to the signed range of OUT_W-2 bits (default −8192..8191). sat = 1 if clamped, else 0.
- Busy behaviour:
  - Toggles arriving outside IDLE stay pending and are accepted on return to IDLE.
  - Two toggles during one busy period cancel; software must wait for ack before the next write.
- Reset values:
  - outp = 0.
  - History, coefficients, acc, sync1, sync2 and last_req = 0.
  - State = INIT. Because INIT primes last_req from sync2, a high inp[31] at reset release is not a request.
- Reset mid-operation: the computation is abandoned and outp returns to 0 on the next clock. The sample being pushed is lost.

## Timing
- Edge 0 is the clk edge that first samples a new inp into sync1. The pending request is seen in IDLE at edge 2.
- PUSH: outp updates at edge TAPS+4 (edge 12 at default parameters). Busy for TAPS+2 cycles after acceptance.
- LOAD/CLEAR/NOP: outp ack toggles at edge 3.
- LOAD/CLEAR take effect at edge 2. A PUSH accepted next uses the updated state.
- outp changes only in the OUT, ACK and reset states. All fields change on the same edge.
- Throughput at back-to-back PUSH: one sample per TAPS+5 cycles, including the synchronizer.

## Test plan
- Reset with inp=0x8000_0000 held, then release → outp stays 0x0000, no ack for 20 cycles.
- LOAD coef[0]=127, others 0; PUSH 100 → result 99, sat=0; ack toggles at edge 12.
- Load all 8 coefs = 16; PUSH 1000 once → 125; after eight PUSHes of 1000 → 1000, sat=0.
- All coefs = 127; PUSH 32767 ×8 → 8191, sat=1; CLEAR; PUSH −32768 with coef[0] only = 127, rest 0 → −8192, sat=1.
- Toggle req while in MAC → processed exactly once after OUT. Two toggles while busy → no extra ack.
- Assert reset during MAC → outp=0 next cycle. Subsequent PUSH 100 with zeroed coefs → result 0, ack=1.
